hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of source-operand ports forwarded per instruction (1..3).
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles (1..4).
REQ-004 SHALL have parameter CNT_W, default 32, performance counter width.
REQ-005 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port: de_valid  in  1  decode stage holds a valid instruction.
REQ-008 SHALL have port: de_rs  in  NUM_SRC x AW  source registers of the decode-stage instruction.
REQ-009 SHALL have port: ex_rs  in  NUM_SRC x AW  source registers of the execute-stage instruction.
REQ-010 SHALL have port: ex_rd / ex_we / ex_is_load  in  AW/1/1  execute-stage destination, write enable, load flag.
REQ-011 SHALL have port: mem_rd / mem_we  in  AW/1  memory-stage destination and write enable.
REQ-012 SHALL have port: wb_rd / wb_we  in  AW/1  writeback-stage destination and write enable.
REQ-013 SHALL have port: redirect  in  1  taken branch/jump resolved in execute.
REQ-014 SHALL have port: src_sel  out  NUM_SRC x hu_src_e  bypass select per execute operand.
REQ-015 SHALL have port: stall_fe / stall_de  out  1/1  hold fetch PC and the fetch-to-decode register.
REQ-016 SHALL have port: flush_de / flush_ex  out  1/1  bubble the decode and execute input registers.
REQ-017 SHALL have port: stall_cnt / flush_cnt  out  CNT_W/CNT_W  performance counters.

Function
REQ-018 Per operand i, src_sel[i] SHALL be combinational:
  - MEM if mem_we, mem_rd==ex_rs[i] and ex_rs[i]!=0;
  - else WB if wb_we, wb_rd==ex_rs[i] and ex_rs[i]!=0;
  - else REG.
  MEM has priority over WB; x0 is never forwarded.
REQ-019 A load-use hit SHALL be de_valid & ex_is_load & ex_we & ex_rd!=0 & (ex_rd equals any de_rs[i]).
REQ-020 The FSM SHALL have states RUN and STALL plus a stall counter scnt of width clog2(LOAD_LAT+1).
REQ-021 In RUN, a hit SHALL combinationally assert stall_fe=stall_de=flush_ex in that cycle.
  - LOAD_LAT>1: next state STALL with scnt=LOAD_LAT-1.
  - LOAD_LAT=1: remain in RUN.
REQ-022 In STALL, the block SHALL assert stall_fe=stall_de=flush_ex, decrement scnt each cycle, and return to RUN when scnt==1, so total stall cycles equal LOAD_LAT exactly.
REQ-023 New hits detected while in STALL SHALL NOT reload scnt.
REQ-024 redirect SHALL assert flush_de=flush_ex=1 in the same cycle and force stall_fe=stall_de=0.
REQ-025 When redirect and a hit (or STALL) coincide, redirect SHALL win: state goes to RUN and scnt to 0 on the next edge.
REQ-026 stall_cnt SHALL increment on every cycle with stall_de=1; flush_cnt SHALL increment on every cycle with redirect=1.
REQ-027 Both counters SHALL saturate at all-ones (no wrap).
REQ-028 When no hit, STALL or redirect is present, all stall/flush outputs SHALL be 0.

Reset
REQ-029 On reset assertion, state SHALL asynchronously become RUN, scnt=0, stall_cnt=0 and flush_cnt=0.
REQ-030 During reset, stall_fe, stall_de, flush_de and flush_ex SHALL be 0; src_sel remains combinational.
REQ-031 Reset asserted mid-STALL SHALL abort the stall immediately; the first post-reset cycle is RUN.

Structure
REQ-032 hu_src_e (REG, MEM, WB) and the FSM state enum SHALL live in the shared riscv_structures package.
REQ-033 Per-operand forwarding SHALL be a generate-instantiated sub-module hu_fwd (ex_rs, mem/wb rd/we -> src); the FSM and counters live in hazard_ctrl.

Verification
REQ-034 The bench SHALL cover: mem_we=1, mem_rd=5, wb_we=1, wb_rd=5, ex_rs[0]=5 -> src_sel[0]=MEM; ex_rs[0]=0 with mem_rd=0 -> REG.
REQ-035 The bench SHALL cover: LOAD_LAT=1, ex_is_load=1, ex_rd=7, de_rs[1]=7 -> stall_de=flush_ex=1 for exactly 1 cycle, stall_cnt=1.
REQ-036 The bench SHALL cover: LOAD_LAT=3, same hit -> stall for 3 consecutive cycles, then RUN, stall_cnt=3.
REQ-037 The bench SHALL cover: LOAD_LAT=3, redirect in the 2nd stall cycle -> flush_de=flush_ex=1 and stall_de=0 that cycle, RUN next, stall_cnt=1, flush_cnt=1.
REQ-038 The bench SHALL cover: CNT_W=4, 20 redirect cycles -> flush_cnt holds 15.
REQ-039 The bench SHALL cover: reset asserted mid-STALL (LOAD_LAT=4) -> all outputs 0 asynchronously, counters 0, no stall after release.

Source files
------------

// File: rtl/riscv_structures_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : riscv_structures (package)                                    |
// | Brief    : Shared pipeline types: bypass-select and hazard FSM encodings |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package riscv_structures;

    typedef enum logic [1:0] {
        REG = 2'd0,
        MEM = 2'd1,
        WB  = 2'd2
    } hu_src_e;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } hu_state_e;

endpackage : riscv_structures
`default_nettype wire

// File: rtl/hu_fwd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hu_fwd                                                        |
// | Brief    : Bypass select for one execute-stage source operand            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hu_fwd
    import riscv_structures::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_we,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_we,
    output hu_src_e       src
);

    logic w_rs_nz;

    assign w_rs_nz = (ex_rs != '0);

    // The youngest producer (memory stage) wins; x0 is hardwired so never bypassed.
    always_comb begin
        src = REG;
        if (mem_we && (mem_rd == ex_rs) && w_rs_nz) begin
            src = MEM;
        end else if (wb_we && (wb_rd == ex_rs) && w_rs_nz) begin
            src = WB;
        end
    end

endmodule : hu_fwd
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_ctrl                                                   |
// | Brief    : Operand forwarding, load-use stall FSM, redirect flush, perf  |
// |            counters for an in-order pipeline                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hazard_ctrl
    import riscv_structures::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          de_valid,
    input  logic [NUM_SRC-1:0][AW-1:0]    de_rs,
    input  logic [NUM_SRC-1:0][AW-1:0]    ex_rs,
    input  logic [AW-1:0]                 ex_rd,
    input  logic                          ex_we,
    input  logic                          ex_is_load,
    input  logic [AW-1:0]                 mem_rd,
    input  logic                          mem_we,
    input  logic [AW-1:0]                 wb_rd,
    input  logic                          wb_we,
    input  logic                          redirect,
    output hu_src_e [NUM_SRC-1:0]         src_sel,
    output logic                          stall_fe,
    output logic                          stall_de,
    output logic                          flush_de,
    output logic                          flush_ex,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    localparam int                c_scnt_w    = $clog2(LOAD_LAT + 1);
    localparam logic [c_scnt_w-1:0] c_scnt_one  = c_scnt_w'(1);
    localparam logic [c_scnt_w-1:0] c_scnt_load = c_scnt_w'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);

    hu_state_e             r_state;
    hu_state_e             w_state_nxt;
    logic [c_scnt_w-1:0]   r_scnt;
    logic [c_scnt_w-1:0]   w_scnt_nxt;
    logic                  w_rs_match;
    logic                  w_hit;
    logic                  w_stall;
    logic                  w_flush_de;
    logic                  w_flush_ex;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
            hu_fwd #(
                .AW (AW)
            ) u_fwd (
                .ex_rs  (ex_rs[gi]),
                .mem_rd (mem_rd),
                .mem_we (mem_we),
                .wb_rd  (wb_rd),
                .wb_we  (wb_we),
                .src    (src_sel[gi])
            );
        end
    endgenerate

    always_comb begin
        w_rs_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (de_rs[i] == ex_rd) begin
                w_rs_match = 1'b1;
            end
        end
    end

    assign w_hit = de_valid & ex_is_load & ex_we & (ex_rd != '0) & w_rs_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_scnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
        end
    end

    // The first stall cycle is the detection cycle itself, so STALL only
    // has to cover the remaining LOAD_LAT-1 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_stall     = 1'b0;
        w_flush_de  = 1'b0;
        w_flush_ex  = 1'b0;
        if (redirect) begin
            w_flush_de  = 1'b1;
            w_flush_ex  = 1'b1;
            w_state_nxt = RUN;
            w_scnt_nxt  = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hit) begin
                        w_stall    = 1'b1;
                        w_flush_ex = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = STALL;
                            w_scnt_nxt  = c_scnt_load;
                        end
                    end
                end
                STALL: begin
                    w_stall    = 1'b1;
                    w_flush_ex = 1'b1;
                    if (r_scnt == c_scnt_one) begin
                        w_state_nxt = RUN;
                        w_scnt_nxt  = '0;
                    end else begin
                        w_scnt_nxt  = r_scnt - c_scnt_one;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_scnt_nxt  = '0;
                end
            endcase
        end
    end

    // Control outputs are squashed while reset is held, independent of inputs.
    assign stall_fe = w_stall    & ~reset;
    assign stall_de = w_stall    & ~reset;
    assign flush_de = w_flush_de & ~reset;
    assign flush_ex = w_flush_ex & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_de && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (redirect && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hazard_ctrl                                                |
// | Brief    : Directed bench for hazard_ctrl at LOAD_LAT 1, 3 and 4          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;
    import riscv_structures::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             de_valid;
    logic [1:0][4:0]  de_rs;
    logic [1:0][4:0]  ex_rs;
    logic [4:0]       ex_rd;
    logic             ex_we;
    logic             ex_is_load;
    logic [4:0]       mem_rd;
    logic             mem_we;
    logic [4:0]       wb_rd;
    logic             wb_we;
    logic             redirect;

    hu_src_e [1:0]    sel1, sel3, sel4;
    logic             sfe1, sde1, fde1, fex1;
    logic             sfe3, sde3, fde3, fex3;
    logic             sfe4, sde4, fde4, fex4;
    logic [31:0]      scnt1, fcnt1, scnt3, fcnt3;
    logic [3:0]       scnt4, fcnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.NUM_SRC(2), .AW(5), .LOAD_LAT(1), .CNT_W(32)) u_l1 (
        .clk(clk), .reset(reset), .de_valid(de_valid), .de_rs(de_rs), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
        .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we), .redirect(redirect),
        .src_sel(sel1), .stall_fe(sfe1), .stall_de(sde1), .flush_de(fde1),
        .flush_ex(fex1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    hazard_ctrl #(.NUM_SRC(2), .AW(5), .LOAD_LAT(3), .CNT_W(32)) u_l3 (
        .clk(clk), .reset(reset), .de_valid(de_valid), .de_rs(de_rs), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
        .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we), .redirect(redirect),
        .src_sel(sel3), .stall_fe(sfe3), .stall_de(sde3), .flush_de(fde3),
        .flush_ex(fex3), .stall_cnt(scnt3), .flush_cnt(fcnt3)
    );

    hazard_ctrl #(.NUM_SRC(2), .AW(5), .LOAD_LAT(4), .CNT_W(4)) u_l4 (
        .clk(clk), .reset(reset), .de_valid(de_valid), .de_rs(de_rs), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
        .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we), .redirect(redirect),
        .src_sel(sel4), .stall_fe(sfe4), .stall_de(sde4), .flush_de(fde4),
        .flush_ex(fex4), .stall_cnt(scnt4), .flush_cnt(fcnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Load in execute writing x7, decode reads x7 on operand 1.
    task automatic set_hit(input logic on);
        de_valid   = on;
        ex_is_load = on;
        ex_we      = on;
        ex_rd      = on ? 5'd7 : 5'd0;
        de_rs[1]   = on ? 5'd7 : 5'd0;
    endtask

    initial begin
        reset = 1'b1; de_valid = 1'b0; de_rs = '0; ex_rs = '0; ex_rd = '0;
        ex_we = 1'b0; ex_is_load = 1'b0; mem_rd = '0; mem_we = 1'b0;
        wb_rd = '0; wb_we = 1'b0; redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall_de", 32'(sde3), 32'd0);
        chk("rst_stall_cnt", scnt3, 32'd0);
        chk("rst_flush_cnt", 32'(fcnt4), 32'd0);
        reset = 1'b0;
        nxt();
        chk("idle_stall_fe", 32'(sfe1), 32'd0);
        chk("idle_flush_de", 32'(fde1), 32'd0);

        // Forwarding priority and x0 exclusion
        mem_we = 1'b1; mem_rd = 5'd5; wb_we = 1'b1; wb_rd = 5'd5;
        ex_rs[0] = 5'd5; ex_rs[1] = 5'd3;
        #1;
        chk("fwd0_mem_prio", 32'(sel3[0]), 32'(MEM));
        chk("fwd1_reg", 32'(sel3[1]), 32'(REG));
        mem_we = 1'b0;
        #1;
        chk("fwd0_wb", 32'(sel3[0]), 32'(WB));
        mem_we = 1'b1; mem_rd = 5'd3; wb_rd = 5'd3;
        #1;
        chk("fwd1_mem", 32'(sel1[1]), 32'(MEM));
        chk("fwd0_nomatch", 32'(sel1[0]), 32'(REG));
        ex_rs[0] = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        #1;
        chk("fwd0_x0", 32'(sel1[0]), 32'(REG));
        mem_we = 1'b0; wb_we = 1'b0; ex_rs = '0;

        // Near-miss load-use patterns must not stall
        nxt();
        set_hit(1'b1); de_valid = 1'b0;
        #1;
        chk("nohit_devalid", 32'(sde3), 32'd0);
        de_valid = 1'b1; ex_rd = 5'd0; de_rs[1] = 5'd0;
        #1;
        chk("nohit_x0", 32'(sde3), 32'd0);
        set_hit(1'b0);

        // Load-use hit held for a single cycle
        nxt();
        set_hit(1'b1);
        #1;
        chk("c0_l1_stall_de", 32'(sde1), 32'd1);
        chk("c0_l1_flush_ex", 32'(fex1), 32'd1);
        chk("c0_l1_stall_fe", 32'(sfe1), 32'd1);
        chk("c0_l3_stall_de", 32'(sde3), 32'd1);
        chk("c0_l3_flush_de", 32'(fde3), 32'd0);
        nxt();
        set_hit(1'b0);
        #1;
        chk("c1_l1_stall_de", 32'(sde1), 32'd0);
        chk("c1_l1_stall_cnt", scnt1, 32'd1);
        chk("c1_l3_stall_de", 32'(sde3), 32'd1);
        chk("c1_l4_stall_de", 32'(sde4), 32'd1);
        nxt();
        chk("c2_l3_stall_de", 32'(sde3), 32'd1);
        chk("c2_l3_flush_ex", 32'(fex3), 32'd1);
        nxt();
        chk("c3_l3_stall_de", 32'(sde3), 32'd0);
        chk("c3_l3_stall_cnt", scnt3, 32'd3);
        chk("c3_l4_stall_de", 32'(sde4), 32'd1);
        nxt();
        chk("c4_l4_stall_de", 32'(sde4), 32'd0);
        chk("c4_l4_stall_cnt", 32'(scnt4), 32'd4);
        chk("c4_l1_stall_cnt", scnt1, 32'd1);

        // Asynchronous counter clear
        reset = 1'b1;
        #1;
        chk("async_clr_cnt", scnt3, 32'd0);
        nxt();
        reset = 1'b0;
        nxt();

        // Redirect in the second stall cycle
        set_hit(1'b1);
        #1;
        chk("d0_l3_stall_de", 32'(sde3), 32'd1);
        nxt();
        set_hit(1'b0); redirect = 1'b1;
        #1;
        chk("d1_l3_flush_de", 32'(fde3), 32'd1);
        chk("d1_l3_flush_ex", 32'(fex3), 32'd1);
        chk("d1_l3_stall_de", 32'(sde3), 32'd0);
        chk("d1_l3_stall_fe", 32'(sfe3), 32'd0);
        nxt();
        redirect = 1'b0;
        #1;
        chk("d2_l3_stall_de", 32'(sde3), 32'd0);
        chk("d2_l3_stall_cnt", scnt3, 32'd1);
        chk("d2_l3_flush_cnt", fcnt3, 32'd1);

        // Twenty more redirect cycles: 4-bit counter saturates
        redirect = 1'b1;
        repeat (20) nxt();
        redirect = 1'b0;
        #1;
        chk("sat_l4_flush_cnt", 32'(fcnt4), 32'd15);
        chk("sat_l3_flush_cnt", fcnt3, 32'd21);

        // Reset asserted in the middle of a LOAD_LAT=4 stall
        nxt();
        set_hit(1'b1);
        nxt();
        set_hit(1'b0);
        #1;
        chk("e1_l4_stall_de", 32'(sde4), 32'd1);
        set_hit(1'b1); redirect = 1'b1;
        mem_we = 1'b1; mem_rd = 5'd9; ex_rs[0] = 5'd9;
        reset = 1'b1;
        #1;
        chk("mrst_stall_de", 32'(sde4), 32'd0);
        chk("mrst_stall_fe", 32'(sfe4), 32'd0);
        chk("mrst_flush_ex", 32'(fex4), 32'd0);
        chk("mrst_flush_de", 32'(fde4), 32'd0);
        chk("mrst_stall_cnt", 32'(scnt4), 32'd0);
        chk("mrst_flush_cnt", 32'(fcnt4), 32'd0);
        chk("mrst_src_sel", 32'(sel4[0]), 32'(MEM));
        set_hit(1'b0); redirect = 1'b0;
        mem_we = 1'b0; mem_rd = 5'd0; ex_rs = '0;
        nxt();
        reset = 1'b0;
        #1;
        chk("post_rst0_stall_de", 32'(sde4), 32'd0);
        nxt();
        chk("post_rst1_stall_de", 32'(sde4), 32'd0);
        chk("post_rst1_stall_cnt", 32'(scnt4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
